// File: rtl/dct_mem_sequencer_pkg.sv
// Shared definitions for the DCT memory sequencer: memory geometry, DCT block
// constants, controller state encoding and the block-phase helper.
package dct_mem_pkg;

  localparam int MEM_WORDS   = 16384;
  localparam int MEM_RA_W    = 10;
  localparam int MEM_CA_W    = 4;
  localparam int MEM_ADDR_W  = MEM_RA_W + MEM_CA_W;
  localparam int DCT_BLK     = 16;
  localparam int DCT_LAT_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_t;

  // Even-numbered blocks see flag 1, odd-numbered blocks see flag 0.
  function automatic logic phase_flag(input logic [MEM_ADDR_W-1:0] addr,
                                      input logic [3:0] blk_log2);
    return ~addr[blk_log2];
  endfunction

endpackage

// File: rtl/dct_mem_sequencer_if.sv
// Memory-side bus of the sequencer: input-memory read port, DCT phase flag
// and output-memory write port.
interface dct_mem_sequencer_if;
  import dct_mem_pkg::*;

  logic [MEM_RA_W-1:0] in_ra;
  logic [MEM_CA_W-1:0] in_ca;
  logic                in_nce;
  logic                in_nwrt;
  logic                dct_flag;
  logic [MEM_RA_W-1:0] out_ra;
  logic [MEM_CA_W-1:0] out_ca;
  logic                out_nce;
  logic                out_nwrt;

  modport master (
    output in_ra, in_ca, in_nce, in_nwrt, dct_flag,
    output out_ra, out_ca, out_nce, out_nwrt
  );

  modport slave (
    input in_ra, in_ca, in_nce, in_nwrt, dct_flag,
    input out_ra, out_ca, out_nce, out_nwrt
  );

endinterface

// File: rtl/dct_mem_sequencer_valid_delay_line.sv
// Fixed-depth 1-bit shift register carrying the read-issued marker through the
// memory + DCT latency; flush clears every stage synchronously.
module valid_delay_line #(
  parameter int DEPTH = 18
) (
  input  logic clk,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (flush) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dct_mem_sequencer.sv
// Runs one DCT pass: streams the input memory into the DCT in address order and
// writes each result to the output memory once the pipeline latency has elapsed.
module dct_mem_sequencer
  import dct_mem_pkg::*;
#(
  parameter int NWORDS  = MEM_WORDS,
  parameter int BLK     = DCT_BLK,
  parameter int RD_LAT  = 1,
  parameter int DCT_LAT = DCT_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  // start is a one-cycle request honoured only in IDLE; busy covers the whole
  // pass and done pulses once after the last write. start outside IDLE only
  // raises start_err.
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       start_err,
  output seq_state_t state_dbg,
  dct_mem_sequencer_if.master mem
);

  localparam int AW       = $clog2(NWORDS);
  localparam int L        = RD_LAT + DCT_LAT;
  localparam int BLK_LOG2 = $clog2(BLK);
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          rd_en_q, rd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_v;
  logic          flush;
  logic          flag_in;
  logic [RD_LAT-1:0] flag_pipe;

  assign flush = ~reset;

  valid_delay_line #(.DEPTH(L)) u_valid_delay_line (
    .clk   (clk),
    .flush (flush),
    .din   (rd_en_q),
    .dout  (wr_v)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (wr_v) wr_addr_d = wr_addr_q + AW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          rd_addr_d = '0;
          wr_addr_d = '0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_READ: begin
        err_d = start;
        if (rd_addr_q == LAST) begin
          state_d   = ST_DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
          rd_en_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        err_d = start;
        if (wr_v && (wr_addr_q == LAST)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_FIN: begin
        err_d   = start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Phase flag follows the issued address through the read latency so it lines
  // up with the word arriving at the DCT input; idle cycles carry 1.
  assign flag_in = rd_en_q ? phase_flag(MEM_ADDR_W'(rd_addr_q), 4'(BLK_LOG2)) : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_pipe <= '1;
    end else begin
      flag_pipe[0] <= flag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        flag_pipe[i] <= flag_pipe[i-1];
      end
    end
  end

  assign {mem.in_ra, mem.in_ca}   = MEM_ADDR_W'(rd_addr_q);
  assign mem.in_nce               = ~rd_en_q;
  assign mem.in_nwrt              = 1'b1;
  assign mem.dct_flag             = flag_pipe[RD_LAT-1];
  assign {mem.out_ra, mem.out_ca} = MEM_ADDR_W'(wr_addr_q);
  assign mem.out_nce              = ~wr_v;
  assign mem.out_nwrt             = ~wr_v;

  assign busy      = busy_q;
  assign done      = done_q;
  assign start_err = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dct_mem_sequencer.sv
// Bench for dct_mem_sequencer: a 32-word instance for cycle-exact pass checks
// and a default-size instance for the full 16384-word pass.
module tb_dct_mem_sequencer;
  import dct_mem_pkg::*;

  localparam int NS   = 32;
  localparam int LS   = 18;
  localparam int NL   = 16384;
  localparam int LL   = 18;
  localparam int RDL  = 1;
  localparam int BLKS = 16;

  typedef struct {
    int          k;
    logic [37:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_s = 1'b0;
  logic start_l = 1'b0;
  logic busy_s, done_s, err_s, busy_l, done_l, err_l;
  seq_state_t st_s, st_l;

  dct_mem_sequencer_if mem_s ();
  dct_mem_sequencer_if mem_l ();

  dct_mem_sequencer #(.NWORDS(NS)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
    .start_err(err_s), .state_dbg(st_s), .mem(mem_s.master)
  );

  dct_mem_sequencer dut_l (
    .clk(clk), .reset(reset), .start(start_l), .busy(busy_l), .done(done_l),
    .start_err(err_l), .state_dbg(st_l), .mem(mem_l.master)
  );

  // clock
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [37:0] obs_tab [0:63];
  vec_t        tab [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [37:0] pk(input logic in_nce, input logic in_nwrt, input int in_addr,
                                     input logic out_nce, input logic out_nwrt, input int out_addr,
                                     input logic flag, input logic busy, input logic done,
                                     input logic err, input seq_state_t st);
    logic [13:0] ia, oa;
    ia = 14'(in_addr);
    oa = 14'(out_addr);
    return {in_nce, in_nwrt, ia, out_nce, out_nwrt, oa, flag, busy, done, err, st};
  endfunction

  function automatic logic [37:0] obs_s();
    return {mem_s.in_nce, mem_s.in_nwrt, mem_s.in_ra, mem_s.in_ca, mem_s.out_nce, mem_s.out_nwrt,
            mem_s.out_ra, mem_s.out_ca, mem_s.dct_flag, busy_s, done_s, err_s, st_s};
  endfunction

  function automatic logic [37:0] obs_l();
    return {mem_l.in_nce, mem_l.in_nwrt, mem_l.in_ra, mem_l.in_ca, mem_l.out_nce, mem_l.out_nwrt,
            mem_l.out_ra, mem_l.out_ca, mem_l.dct_flag, busy_l, done_l, err_l, st_l};
  endfunction

  function automatic logic [37:0] idle_vec();
    return pk(1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE);
  endfunction

  // Expected outputs of the small instance in cycle k after the start edge.
  function automatic logic [37:0] exp_s(input int k, input logic err);
    logic rd, wr, fl;
    int w;
    seq_state_t st;
    rd = (k >= 1) && (k <= NS);
    wr = (k >= LS + 1) && (k <= LS + NS);
    w  = k - 1 - RDL;
    fl = ((w >= 0) && (w < NS)) ? (((w / BLKS) % 2) == 0) : 1'b1;
    if (k <= NS) st = ST_READ;
    else if (k <= LS + NS) st = ST_DRAIN;
    else if (k == LS + NS + 1) st = ST_FIN;
    else st = ST_IDLE;
    return pk(~rd, 1'b1, rd ? k - 1 : 0, ~wr, ~wr, wr ? k - LS - 1 : 0, fl,
              k <= LS + NS, k == LS + NS + 1, err, st);
  endfunction

  // Caller raises start_s at a negedge; extra start pulses go in at e1..e3.
  task automatic run_small(input int e1, input int e2, input int e3, input int rst_k,
                           input bit record);
    logic [37:0] act;
    logic        e_err;
    for (int k = 1; k <= LS + NS + 2; k++) begin
      @(negedge clk);
      act = obs_s();
      if (record) obs_tab[k] = act;
      e_err = (k > 1) && ((k - 1 == e1) || (k - 1 == e2) || (k - 1 == e3));
      check($sformatf("pass_k%0d", k), 64'(act), 64'(exp_s(k, e_err)));
      start_s = 1'b0;
      if (k == e1 || k == e2 || k == e3) start_s = 1'b1;
      if (k == rst_k) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int rd_cnt, wr_cnt, rd_bad, wr_bad, done_cyc, done_cnt, bad;
    logic [9:0] last_ra;
    logic [3:0] last_ca;

    tab[0]  = '{1,  pk(0, 1, 0,  1, 1, 0,  1, 1, 0, 0, ST_READ)};
    tab[1]  = '{2,  pk(0, 1, 1,  1, 1, 0,  1, 1, 0, 0, ST_READ)};
    tab[2]  = '{17, pk(0, 1, 16, 1, 1, 0,  1, 1, 0, 0, ST_READ)};
    tab[3]  = '{18, pk(0, 1, 17, 1, 1, 0,  0, 1, 0, 0, ST_READ)};
    tab[4]  = '{19, pk(0, 1, 18, 0, 0, 0,  0, 1, 0, 0, ST_READ)};
    tab[5]  = '{32, pk(0, 1, 31, 0, 0, 13, 0, 1, 0, 0, ST_READ)};
    tab[6]  = '{33, pk(1, 1, 0,  0, 0, 14, 0, 1, 0, 0, ST_DRAIN)};
    tab[7]  = '{34, pk(1, 1, 0,  0, 0, 15, 1, 1, 0, 0, ST_DRAIN)};
    tab[8]  = '{50, pk(1, 1, 0,  0, 0, 31, 1, 1, 0, 0, ST_DRAIN)};
    tab[9]  = '{51, pk(1, 1, 0,  1, 1, 0,  1, 0, 1, 0, ST_FIN)};
    tab[10] = '{52, pk(1, 1, 0,  1, 1, 0,  1, 0, 0, 0, ST_IDLE)};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_small", 64'(obs_s()), 64'(idle_vec()));
    check("reset_large", 64'(obs_l()), 64'(idle_vec()));
    reset = 1'b1;

    // plain pass, compared against the hand-computed table
    start_s = 1'b1;
    run_small(0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("table_k%0d", tab[i].k), 64'(obs_tab[tab[i].k]), 64'(tab[i].exp));
    end

    // back-to-back pass at the earliest edge, with stray starts in READ, DRAIN and FIN
    start_s = 1'b1;
    run_small(5, 40, 51, 0, 1'b0);
    @(negedge clk);
    check("idle_after_fin_start", 64'(obs_s()), 64'(idle_vec()));

    // reset in the middle of DRAIN
    start_s = 1'b1;
    run_small(0, 0, 0, 40, 1'b0);
    @(negedge clk);
    check("rst_mid_drain", 64'(obs_s()), 64'(idle_vec()));
    reset = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (!mem_s.out_nwrt || !mem_s.out_nce || !mem_s.in_nce || busy_s) bad++;
    end
    check("no_strobe_after_rst", 64'(bad), 64'(0));
    start_s = 1'b1;
    run_small(0, 0, 0, 0, 1'b0);

    // full-size pass
    rd_cnt = 0; wr_cnt = 0; rd_bad = 0; wr_bad = 0; done_cyc = -1; done_cnt = 0;
    last_ra = '0; last_ca = '0;
    @(negedge clk);
    start_l = 1'b1;
    for (int cyc = 1; cyc <= NL + LL + 10; cyc++) begin
      @(negedge clk);
      start_l = 1'b0;
      if (!mem_l.in_nce) begin
        if ({mem_l.in_ra, mem_l.in_ca} != 14'(rd_cnt)) rd_bad++;
        last_ra = mem_l.in_ra;
        last_ca = mem_l.in_ca;
        rd_cnt++;
      end
      if (!mem_l.out_nwrt) begin
        if ({mem_l.out_ra, mem_l.out_ca} != 14'(wr_cnt)) wr_bad++;
        wr_cnt++;
      end
      if (done_l) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    check("large_reads", 64'(rd_cnt), 64'(NL));
    check("large_read_order", 64'(rd_bad), 64'(0));
    check("large_last_ra", 64'(last_ra), 64'(1023));
    check("large_last_ca", 64'(last_ca), 64'(15));
    check("large_writes", 64'(wr_cnt), 64'(NL));
    check("large_write_order", 64'(wr_bad), 64'(0));
    check("large_done_cycle", 64'(done_cyc), 64'(NL + LL + 1));
    check("large_done_count", 64'(done_cnt), 64'(1));
    check("large_idle_after", 64'(obs_l()), 64'(idle_vec()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
